// File: rtl/tile_layer_engine.sv
// Per-scanline tile layer renderer: fetches one row of tile entries, then each tile's
// pattern row, and streams scrolled, mirrored, palettised pixels into the line buffer.
module tile_layer_engine #(
  parameter int LAYER          = 0,
  parameter int TILES_PER_WORD = 4,
  parameter int MAP_LOG2       = 6,
  parameter int SCREEN_TILES   = 40,
  parameter int RAM_LATENCY    = 2,
  localparam int TPW_LOG2      = $clog2(TILES_PER_WORD),
  localparam int TA_W          = 1 + 2*MAP_LOG2 - TPW_LOG2,
  localparam int W             = 8*SCREEN_TILES,
  localparam int LB_AW         = $clog2(W)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [8:0]                   row,
  input  logic [31:0]                  scroll,
  input  logic                         enable,
  output logic [TA_W-1:0]              tram_addr,
  input  logic [16*TILES_PER_WORD-1:0] tram_rddata,
  output logic [12:0]                  pram_addr,
  input  logic [31:0]                  pram_rddata,
  output logic                         lb_wren,
  output logic [LB_AW-1:0]             lb_wraddr,
  output logic [7:0]                   lb_wrdata,
  output logic                         busy,
  output logic                         done
);

  localparam int NCH   = SCREEN_TILES/TILES_PER_WORD + 1;
  localparam int NENT  = NCH*TILES_PER_WORD;
  localparam int CW    = MAP_LOG2 - TPW_LOG2;
  localparam int TLEN  = NCH + RAM_LATENCY;
  localparam int PLEN  = RAM_LATENCY + 8*(SCREEN_TILES+1);
  localparam int CNT_W = $clog2(PLEN + TLEN);
  localparam int EW    = $clog2(NENT);
  localparam int NIW   = $clog2(NCH);
  localparam int XW    = LB_AW + 2;

  typedef enum logic [1:0] {IDLE, TFETCH, PFETCH, DONE} state_t;

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic                         accept;
  logic [8:0]                   ey_in;
  logic [MAP_LOG2-1:0]          trow_in, trow;
  logic [CW-1:0]                tcol_in, tcol;
  logic [TPW_LOG2-1:0]          toff;
  logic [2:0]                   prow, px;
  logic                         en;
  logic [16*TILES_PER_WORD-1:0] tile_buf [NCH];
  logic [31:0]                  pat_p1;

  logic                         iss_load;
  logic [EW-1:0]                iss_e;
  logic [15:0]                  iss_ent;
  logic                         pix_act;
  logic [CNT_W-1:0]             q;
  logic [EW-1:0]                pix_e;
  logic [15:0]                  pix_ent;
  logic [31:0]                  pat;
  logic [2:0]                   nib;
  logic [3:0]                   color;
  logic signed [XW-1:0]         x;
  logic                         unused_bits;

  function automatic logic [TA_W-1:0] tram_word(input logic [MAP_LOG2-1:0] r,
                                                input logic [CW-1:0] c,
                                                input logic [CW-1:0] k);
    logic [CW-1:0] col;
    col = c + k;
    return {1'(LAYER), r, col};
  endfunction

  function automatic logic [15:0] pick(input logic [16*TILES_PER_WORD-1:0] word,
                                       input logic [TPW_LOG2-1:0] slot);
    return word[16*slot +: 16];
  endfunction

  function automatic logic [7:0] pixel_word(input logic on, input logic [3:0] pal,
                                            input logic [3:0] c);
    return (!on || c == 4'd0) ? 8'h00 : {pal, c};
  endfunction

  assign accept      = (state == IDLE) && start;
  assign ey_in       = scroll[24:16] + row;
  assign trow_in     = MAP_LOG2'(ey_in[8:3]);
  assign tcol_in     = CW'(scroll[8:3] >> TPW_LOG2);
  assign unused_bits = ^{scroll[31:25], scroll[15:9], iss_ent[14:10], pix_ent[15], pix_ent[9:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = TFETCH;
      TFETCH:  if (cnt == CNT_W'(TLEN-1)) state_nxt = PFETCH;
      PFETCH:  if (cnt == CNT_W'(PLEN-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pattern issue: tile 0 is loaded on the last TFETCH edge, tile j on PFETCH cycle 8j-1
  always_comb begin
    iss_load = ((state == TFETCH) && (cnt == CNT_W'(TLEN-1))) ||
               ((state == PFETCH) && (cnt[2:0] == 3'd7) && ((cnt >> 3) < CNT_W'(SCREEN_TILES)));
    iss_e    = EW'(((state == TFETCH) ? CNT_W'(0) : (cnt >> 3) + CNT_W'(1)) + CNT_W'(toff));
    iss_ent  = pick(tile_buf[NIW'(iss_e >> TPW_LOG2)], iss_e[TPW_LOG2-1:0]);
  end

  // pixel stage: q = 8j + p counts pixels since the first pattern row returned
  always_comb begin
    pix_act = (state == PFETCH) && (cnt >= CNT_W'(RAM_LATENCY));
    q       = cnt - CNT_W'(RAM_LATENCY);
    pix_e   = EW'((q >> 3) + CNT_W'(toff));
    pix_ent = pick(tile_buf[NIW'(pix_e >> TPW_LOG2)], pix_e[TPW_LOG2-1:0]);
    pat     = (q[2:0] == 3'd0) ? pram_rddata : pat_p1;
    nib     = pix_ent[14] ? ~q[2:0] : q[2:0];
    color   = pat[4*nib +: 4];
    x       = $signed(XW'(q)) - $signed(XW'(px));
  end

  always_comb begin
    busy      = (state == TFETCH) || (state == PFETCH);
    done      = (state == DONE);
    lb_wren   = pix_act && !x[XW-1] && (x[XW-2:0] < (XW-1)'(W));
    lb_wraddr = lb_wren ? x[LB_AW-1:0] : '0;
    lb_wrdata = lb_wren ? pixel_word(en, pix_ent[13:10], color) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tram_addr <= '0;
      pram_addr <= '0;
    end else begin
      cnt <= (state_nxt != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
      if (accept)
        tram_addr <= tram_word(trow_in, tcol_in, '0);
      else if ((state == TFETCH) && (cnt < CNT_W'(NCH-1)))
        tram_addr <= tram_word(trow, tcol, CW'(cnt + CNT_W'(1)));
      if (iss_load)
        pram_addr <= {iss_ent[9:0], iss_ent[15] ? ~prow : prow};
    end
  end

  // line parameters latched on accept; tile words captured RAM_LATENCY after issue
  always_ff @(posedge clk) begin
    if (accept) begin
      trow <= trow_in;
      prow <= ey_in[2:0];
      tcol <= tcol_in;
      toff <= scroll[3 +: TPW_LOG2];
      px   <= scroll[2:0];
      en   <= enable;
    end
    if ((state == TFETCH) && (cnt >= CNT_W'(RAM_LATENCY)))
      tile_buf[NIW'(cnt - CNT_W'(RAM_LATENCY))] <= tram_rddata;
    if (pix_act && (q[2:0] == 3'd0))
      pat_p1 <= pram_rddata;
  end

endmodule

// File: tb/tb_tile_layer_engine.sv
// Bench for tile_layer_engine: RAM models, table of scanline vectors with a pixel
// scoreboard, plus hand-written abort-by-reset sequence.
module tb_tile_layer_engine;
  localparam int RL   = 2;
  localparam int NCH  = 11;
  localparam int W    = 320;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  row;
  logic [31:0] scroll;
  logic        enable;
  logic [10:0] tram_addr;
  logic [63:0] tram_rddata;
  logic [12:0] pram_addr;
  logic [31:0] pram_rddata;
  logic        lb_wren;
  logic [8:0]  lb_wraddr;
  logic [7:0]  lb_wrdata;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  tile_layer_engine #(.LAYER(0), .TILES_PER_WORD(4), .MAP_LOG2(6), .SCREEN_TILES(40),
                      .RAM_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row), .scroll(scroll), .enable(enable),
    .tram_addr(tram_addr), .tram_rddata(tram_rddata), .pram_addr(pram_addr),
    .pram_rddata(pram_rddata), .lb_wren(lb_wren), .lb_wraddr(lb_wraddr),
    .lb_wrdata(lb_wrdata), .busy(busy), .done(done));

  logic [63:0] tram_mem [2048];
  logic [31:0] pram_mem [8192];
  logic [63:0] tpipe [RL];
  logic [31:0] ppipe [RL];

  always @(posedge clk) begin
    tpipe[0] <= tram_mem[tram_addr];
    ppipe[0] <= pram_mem[pram_addr];
    for (int i = 1; i < RL; i++) begin
      tpipe[i] <= tpipe[i-1];
      ppipe[i] <= ppipe[i-1];
    end
  end
  assign tram_rddata = tpipe[RL-1];
  assign pram_rddata = ppipe[RL-1];

  int checks = 0;
  int errors = 0;
  logic [16:0] sb_q [$];

  typedef struct {
    string name;
    int    x, y, r;
    bit    en;
    int    mode;
    bit    poke;
    int    exp_ta0;
    int    exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < 2048; a++) tram_mem[a] = {$urandom, $urandom};
    for (int a = 0; a < 8192; a++) pram_mem[a] = $urandom;
    if (mode == 0) begin
      for (int c = 0; c < 64; c++) tram_mem[c >> 2][16*(c % 4) +: 16] = {2'b00, 4'd1, 10'(c)};
      for (int a = 0; a < 8192; a++) pram_mem[a] = 32'h3333_3333;
    end else if (mode == 2) begin
      tram_mem[0][15:0] = {1'b1, 1'b1, 4'd5, 10'd7};
      pram_mem[{10'd7, 3'd7}] = 32'h8765_4321;
    end
  endtask

  // map pixel column = X + screen x; tile column and pixel follow directly from it
  function automatic logic [7:0] exp_pix(input int sx, input int sy, input int r,
                                         input bit en, input int xx);
    int ey, mx, col, p, pr, pi;
    logic [63:0] w;
    logic [15:0] ent;
    logic [31:0] pt;
    logic [3:0]  c;
    ey  = (sy + r) % 512;
    mx  = (sx + xx) % 512;
    col = mx >> 3;
    p   = mx % 8;
    w   = tram_mem[{1'b0, 6'(ey >> 3), 4'(col >> 2)}];
    ent = w[16*(col % 4) +: 16];
    pr  = ent[15] ? 7 - (ey % 8) : ey % 8;
    pt  = pram_mem[{ent[9:0], 3'(pr)}];
    pi  = ent[14] ? 7 - p : p;
    c   = pt[4*pi +: 4];
    return (!en || c == 4'd0) ? 8'h00 : {ent[13:10], c};
  endfunction

  task automatic run_line(input vec_t v);
    int n, ey, col, pr, exp_ta;
    bit fin;
    logic [15:0] ent;
    logic [12:0] exp_pa;
    logic [16:0] e;
    fill(v.mode);
    sb_q.delete();
    for (int xx = 0; xx < W; xx++) sb_q.push_back({9'(xx), exp_pix(v.x, v.y, v.r, v.en, xx)});
    ey     = (v.y + v.r) % 512;
    col    = (v.x >> 3) % 64;
    ent    = tram_mem[{1'b0, 6'(ey >> 3), 4'(col >> 2)}][16*(col % 4) +: 16];
    pr     = ent[15] ? 7 - (ey % 8) : ey % 8;
    exp_pa = {ent[9:0], 3'(pr)};
    @(negedge clk);
    row    = 9'(v.r);
    scroll = {7'd0, 9'(v.y), 7'd0, 9'(v.x)};
    enable = v.en;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    fin   = 1'b0;
    check({v.name, "_busy_first"}, busy, 1);
    check({v.name, "_tram_addr0"}, tram_addr, v.exp_ta0);
    while (!fin && n < 1000) begin
      if (n <= NCH) begin
        exp_ta = ((ey >> 3) % 64) * 16 + (((v.x >> 3) / 4 + n - 1) % 16);
        check({v.name, "_tram_addr"}, tram_addr, exp_ta);
      end
      if (n == NCH + RL + 1) check({v.name, "_pram_addr_tile0"}, pram_addr, exp_pa);
      if (v.poke && n == 100) begin
        start  = 1'b1;
        row    = ~row;
        scroll = $urandom;
        enable = ~enable;
      end
      if (v.poke && n == 101) start = 1'b0;
      if (lb_wren) begin
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 17'h1FFFF;
        check({v.name, "_pixel"}, {lb_wraddr, lb_wrdata}, e);
      end
      if (done) begin
        fin = 1'b1;
        check({v.name, "_done_cycle"}, n, v.exp_done);
        check({v.name, "_busy_at_done"}, busy, 0);
        check({v.name, "_missing_writes"}, sb_q.size(), 0);
        start = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles", v.name, n);
    end
    @(negedge clk);
    start = 1'b0;
    check({v.name, "_idle_after1"}, busy, 0);
    @(negedge clk);
    check({v.name, "_idle_after2"}, {busy, done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0] = '{"basic",   0,      0,      0,   1'b1, 0, 1'b0, 0,   344};
    vecs[1] = '{"xscroll", 13,     0,      0,   1'b1, 1, 1'b0, 0,   344};
    vecs[2] = '{"wrap",    'h1F8,  'h1FF,  3,   1'b1, 1, 1'b0, 15,  344};
    vecs[3] = '{"mirror",  0,      0,      0,   1'b1, 2, 1'b0, 0,   344};
    vecs[4] = '{"disable", 77,     100,    50,  1'b0, 1, 1'b1, 290, 344};
    vecs[5] = '{"poke",    200,    300,    260, 1'b1, 1, 1'b1, 102, 344};

    rst_n  = 1'b0;
    start  = 1'b0;
    row    = '0;
    scroll = '0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tram_addr", tram_addr, 0);
    check("rst_pram_addr", pram_addr, 0);
    check("rst_lb_wren", lb_wren, 0);
    check("rst_lb_wraddr", lb_wraddr, 0);
    check("rst_lb_wrdata", lb_wrdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_line(vecs[i]);

    fill(1);
    @(negedge clk);
    row    = 9'd5;
    scroll = {7'd0, 9'd20, 7'd0, 9'd3};
    enable = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_wren_before", lb_wren, 1);
    rst_n = 1'b0;
    #1;
    check("abort_wren", lb_wren, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pram_addr", pram_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (20) begin
      @(negedge clk);
      if (lb_wren || busy || done) seen++;
    end
    check("abort_stays_idle", seen, 0);
    run_line(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
